bus_master_arbiter: RTL and testbench
=====================================

Name: bus_master_arbiter

Overview:
- Shares the CPU core's external 6502/6510-style bus between the CPU and two external bus masters (DMA, video/refresh fetch).
- Sequences the handover at bus-cycle granularity:
  - halts the CPU via RDY, honouring write cycles;
  - tristates the CPU bus via AEC, with one turnaround cycle each way;
  - grants the bus round-robin, with an optional hold limit.
- Sits beside the CPU core. Its rdy_o/aec_o are ANDed with the pad RDY/AEC inputs before they reach the core.

Parameters:
- HOLD_MAX, 16, maximum bus cycles one master keeps the bus while the other is requesting; 0 = unlimited.
- CW, 5, hold counter width; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk_i  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- cyc_end  input  1  one-clk_i pulse on the last clock of each bus cycle (PH2 falling).
- cpu_rwn  input  1  CPU RWn for the current bus cycle; 1 = read.
- rdy_writes  input  1  1: CPU honours RDY on write cycles too.
- req  input  2  bus requests; req[0] = DMA, req[1] = video. Held high until the master is done.
- gnt  output  2  one-hot bus grant; master may drive A/D/RWn only while its bit is 1.
- rdy_o  output  1  RDY to CPU; 0 = halt.
- aec_o  output  1  AEC to CPU; 0 = CPU address/data/RWn tristated.
- busy  output  1  1 whenever state is not CPU.

Behaviour:
- All outputs are registered, decoded from state. State advances only on clocks where cyc_end=1, except the reset path.
- Reset (async, any time, including mid-grant):
  - state=CPU, rdy_o=1, aec_o=1, gnt=00, busy=0;
  - round-robin pointer last=1, so req[0] wins the first tie;
  - hold counter=0.
- States and outputs (rdy_o / aec_o / gnt):
  - CPU: 1 / 1 / 00.
  - STALL: 0 / 1 / 00.
  - OFF: 0 / 0 / 00.
  - GRANT: 0 / 0 / one-hot.
  - ON: 0 / 0 / 00.
- CPU -> STALL: cyc_end with req != 00. rdy_o falls on the next clk_i edge.
- STALL exits, at cyc_end:
  - req == 00 -> CPU (request withdrawn).
  - Otherwise, if cpu_rwn=1 or rdy_writes=1 -> OFF. The CPU is now frozen.
  - Otherwise stay in STALL, since a write cycle cannot be halted. No limit on consecutive writes.
- OFF: exactly one bus cycle of turnaround.
  - Winner is chosen at OFF's cyc_end: if both request, the master != last wins; otherwise the single requester wins.
  - If req == 00 at that point -> ON.
  - Else -> GRANT(winner), last <= winner, hold counter <= 0.
- GRANT(w), at each cyc_end:
  - Hold counter increments, saturating at HOLD_MAX.
  - Exit -> OFF if req[w]=0, or if HOLD_MAX != 0, counter+1 >= HOLD_MAX and req[~w]=1.
  - Otherwise stay in GRANT.
  - gnt clears on the clock after the exiting cyc_end. OFF then re-arbitrates, giving one dead bus cycle between masters.
- ON: exactly one bus cycle with aec_o=0 and gnt=00, so the external master's drivers release. Then -> CPU; aec_o and rdy_o rise together.
- New requests arriving during GRANT or OFF are served via OFF re-arbitration; the CPU is not resumed in between.
- If req[w] drops and rises again within the same bus cycle, only the value sampled at cyc_end counts.
- Invariants (verification asserts these):
  - gnt is never 11;
  - gnt != 00 implies aec_o=0;
  - aec_o=0 implies rdy_o=0;
  - at most one state change per cyc_end.

Test Plan:
- Reset, idle: req=00, 10 bus cycles -> rdy_o=1, aec_o=1, gnt=00, busy=0 throughout.
- Single DMA on read cycle: req=01 raised, cpu_rwn=1, req held 5 bus cycles then dropped.
  - States CPU, STALL, OFF, GRANT(x5), OFF, ON, CPU.
  - gnt=01 for exactly 5 bus cycles; aec_o=0 for 8 bus cycles.
- Write stall: req=01, rdy_writes=0, cpu_rwn=0 for 3 bus cycles then 1.
  - aec_o stays 1 through 3 STALL cycles, falls after the first read cyc_end.
  - Repeat with rdy_writes=1: falls after the first STALL cycle.
- Contention and hold limit: HOLD_MAX=4, req=11 continuously.
  - Grants alternate 01 (4 cycles), gap, 10 (4 cycles), gap, ...
  - Each OFF gap is 1 bus cycle with gnt=00; the CPU never resumes.
- Withdrawn request: req=01 asserted, then dropped before STALL's cyc_end with cpu_rwn=0 -> returns to CPU; aec_o never falls.
- Async reset mid-grant: rst_n=0 while gnt=10, asserted away from clk_i edges.
  - gnt=00, aec_o=1, rdy_o=1 immediately.
  - After release with req=11, the first grant is 01.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Shares the CPU's external bus with two external masters (DMA, video).
// Halts the CPU via RDY, tristates it via AEC, and grants round-robin with a hold limit.
module bus_master_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CW       = 5
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       cyc_end,
  input  logic       cpu_rwn,
  input  logic       rdy_writes,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       rdy_o,
  output logic       aec_o,
  output logic       busy
);

  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] HOLD_LIM = CW1'(HOLD_MAX);

  typedef enum logic [2:0] {
    S_CPU   = 3'd0,
    S_STALL = 3'd1,
    S_OFF   = 3'd2,
    S_GRANT = 3'd3,
    S_ON    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_owner;
  logic          w_owner_nx;
  logic          r_last;
  logic          w_last_nx;
  logic [CW-1:0] r_hold;
  logic [CW-1:0] w_hold_nx;
  logic [1:0]    r_gnt;
  logic          r_rdy;
  logic          r_aec;
  logic          r_busy;

  logic [CW:0]   w_hold_inc;
  logic          w_win;
  logic          w_own_req;
  logic          w_oth_req;
  logic          w_limit_hit;

  // Arbitration helpers: on a tie the master that did not win last time goes next.
  assign w_hold_inc  = {1'b0, r_hold} + CW1'(1);
  assign w_win       = (req == 2'b11) ? ~r_last : req[1];
  assign w_own_req   = req[r_owner];
  assign w_oth_req   = req[~r_owner];
  assign w_limit_hit = (HOLD_MAX != 0) && (w_hold_inc >= HOLD_LIM) && w_oth_req;

  // Next state; everything moves only on the last clock of a bus cycle.
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_last_nx  = r_last;
    w_hold_nx  = r_hold;
    if (cyc_end) begin
      case (r_state)
        S_CPU: begin
          if (req != 2'b00) w_state_nx = S_STALL;
        end
        S_STALL: begin
          if (req == 2'b00)              w_state_nx = S_CPU;
          else if (cpu_rwn || rdy_writes) w_state_nx = S_OFF;
        end
        S_OFF: begin
          if (req == 2'b00) begin
            w_state_nx = S_ON;
          end else begin
            w_state_nx = S_GRANT;
            w_owner_nx = w_win;
            w_last_nx  = w_win;
            w_hold_nx  = '0;
          end
        end
        S_GRANT: begin
          if (w_hold_inc <= HOLD_LIM) w_hold_nx = w_hold_inc[CW-1:0];
          if (!w_own_req || w_limit_hit) w_state_nx = S_OFF;
        end
        S_ON: begin
          w_state_nx = S_CPU;
        end
        default: begin
          w_state_nx = S_CPU;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state so they are registered.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CPU;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_hold  <= '0;
      r_gnt   <= 2'b00;
      r_rdy   <= 1'b1;
      r_aec   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_last  <= w_last_nx;
      r_hold  <= w_hold_nx;
      r_rdy   <= (w_state_nx == S_CPU);
      r_aec   <= (w_state_nx == S_CPU) || (w_state_nx == S_STALL);
      r_busy  <= (w_state_nx != S_CPU);
      r_gnt   <= (w_state_nx == S_GRANT) ? (w_owner_nx ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign gnt   = r_gnt;
  assign rdy_o = r_rdy;
  assign aec_o = r_aec;
  assign busy  = r_busy;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: directed handover scenarios plus random traffic,
// all checked every clock against a bus-cycle-level reference model.
module tb_bus_master_arbiter;

  localparam int unsigned HOLD = 4;
  localparam int          CLKS = 4;

  localparam int P_CPU   = 0;
  localparam int P_STALL = 1;
  localparam int P_OFF   = 2;
  localparam int P_GRANT = 3;
  localparam int P_ON    = 4;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b1;
  logic       cyc_end = 1'b0;
  logic       cpu_rwn = 1'b1;
  logic       rdy_writes = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic       rdy_o;
  logic       aec_o;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  logic [1:0] o_gnt;
  logic       o_aec;
  logic       o_rdy;

  always #5 clk_i = ~clk_i;

  bus_master_arbiter #(.HOLD_MAX(HOLD), .CW(5)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .cyc_end    (cyc_end),
    .cpu_rwn    (cpu_rwn),
    .rdy_writes (rdy_writes),
    .req        (req),
    .gnt        (gnt),
    .rdy_o      (rdy_o),
    .aec_o      (aec_o),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one phase per bus cycle, advanced at the clock edge that ends it.
  int m_phase;
  int m_owner;
  int m_last;
  int m_held;

  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return r[1] ? 1 : 0;
  endfunction

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_CPU;
      m_owner <= 0;
      m_last  <= 1;
      m_held  <= 0;
    end else if (cyc_end) begin
      case (m_phase)
        P_CPU:   if (req != 2'b00) m_phase <= P_STALL;
        P_STALL: begin
          if (req == 2'b00)               m_phase <= P_CPU;
          else if (cpu_rwn || rdy_writes) m_phase <= P_OFF;
        end
        P_OFF: begin
          if (req == 2'b00) begin
            m_phase <= P_ON;
          end else begin
            m_phase <= P_GRANT;
            m_owner <= pick(req, m_last);
            m_last  <= pick(req, m_last);
            m_held  <= 0;
          end
        end
        P_GRANT: begin
          m_held <= m_held + 1;
          if (!req[m_owner] || (m_held + 1 >= int'(HOLD) && req[1 - m_owner])) m_phase <= P_OFF;
        end
        default: m_phase <= P_CPU;
      endcase
    end
  end

  logic [1:0] e_gnt;
  logic       e_rdy;
  logic       e_aec;
  logic       e_busy;
  assign e_rdy  = (m_phase == P_CPU);
  assign e_aec  = (m_phase == P_CPU) || (m_phase == P_STALL);
  assign e_busy = (m_phase != P_CPU);
  assign e_gnt  = (m_phase != P_GRANT) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);

  // Per-clock comparison against the model plus the structural invariants.
  always @(negedge clk_i) begin
    if (cmp_en && rst_n) begin
      chk("gnt",  32'(gnt),   32'(e_gnt));
      chk("rdy",  32'(rdy_o), 32'(e_rdy));
      chk("aec",  32'(aec_o), 32'(e_aec));
      chk("busy", 32'(busy),  32'(e_busy));
      chk("inv_gnt_onehot", 32'(gnt == 2'b11), 32'(0));
      chk("inv_gnt_aec", 32'((gnt != 2'b00) && aec_o), 32'(0));
      chk("inv_aec_rdy", 32'(!aec_o && rdy_o), 32'(0));
    end
  end

  // One bus cycle of CLKS clocks; o_* capture the outputs seen during this bus cycle.
  task automatic bus_cyc(input logic [1:0] r, input logic rw, input logic rdw, input bit glitch);
    for (int k = 0; k < CLKS; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        o_gnt = gnt;
        o_aec = aec_o;
        o_rdy = rdy_o;
      end
      req        = (glitch && k == 1) ? ~r : r;
      cpu_rwn    = rw;
      rdy_writes = rdw;
      cyc_end    = (k == CLKS - 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    cyc_end = 1'b0;
    req     = 2'b00;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         cnt_g;
    int         cnt_a;
    int         first_a;
    logic [1:0] exp_c [17];
    logic [1:0] r;
    logic       rw;
    logic       rdw;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt",  32'(gnt),   32'(0));
    chk("rst_rdy",  32'(rdy_o), 32'(1));
    chk("rst_aec",  32'(aec_o), 32'(1));
    chk("rst_busy", 32'(busy),  32'(0));
    #24 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Idle
    for (int i = 0; i < 10; i++) begin
      bus_cyc(2'b00, 1'b1, 1'b0, 1'b0);
      chk("idle_rdy", 32'(o_rdy), 32'(1));
      chk("idle_aec", 32'(o_aec), 32'(1));
      chk("idle_gnt", 32'(o_gnt), 32'(0));
    end

    // Single DMA on read cycles, request held through five grant cycles
    cnt_g = 0;
    cnt_a = 0;
    for (int i = 1; i <= 14; i++) begin
      bus_cyc((i <= 7) ? 2'b01 : 2'b00, 1'b1, 1'b0, 1'b0);
      if (o_gnt == 2'b01) cnt_g++;
      if (!o_aec) cnt_a++;
    end
    chk("dma_gnt_cycles", 32'(cnt_g), 32'(5));
    chk("dma_aec_low_cycles", 32'(cnt_a), 32'(8));

    // Write stall, first without then with RDY honoured on writes
    for (int v = 0; v < 2; v++) begin
      first_a = 0;
      for (int i = 1; i <= 12; i++) begin
        bus_cyc((i <= 7) ? 2'b01 : 2'b00, (i <= 4) ? 1'b0 : 1'b1, v[0], 1'b0);
        if (!o_aec && first_a == 0) first_a = i;
      end
      chk(v == 0 ? "wstall_aec_fall" : "wstall_rdw_aec_fall", 32'(first_a), (v == 0) ? 32'(6) : 32'(3));
    end

    // Contention with hold limit, from a fresh reset
    do_reset();
    exp_c = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
              2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 17; i++) begin
      bus_cyc(2'b11, 1'b1, 1'b0, 1'b0);
      chk("contend_gnt", 32'(o_gnt), 32'(exp_c[i]));
      if (i >= 1) chk("contend_cpu_halted", 32'(o_rdy), 32'(0));
    end
    for (int i = 0; i < 6; i++) bus_cyc(2'b00, 1'b1, 1'b0, 1'b0);

    // Withdrawn request during a write stall
    cnt_a = 0;
    for (int i = 1; i <= 4; i++) begin
      bus_cyc((i == 1) ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0);
      if (!o_aec) cnt_a++;
      if (i == 2) chk("withdraw_stall_rdy", 32'(o_rdy), 32'(0));
      if (i == 3) chk("withdraw_back_rdy", 32'(o_rdy), 32'(1));
    end
    chk("withdraw_aec_low_cycles", 32'(cnt_a), 32'(0));

    // Async reset in the middle of a video grant
    for (int i = 0; i < 3; i++) bus_cyc(2'b10, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    cyc_end = 1'b0;
    chk("pre_reset_gnt", 32'(gnt), 32'(2'b10));
    @(posedge clk_i);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_gnt",  32'(gnt),   32'(0));
    chk("midrst_aec",  32'(aec_o), 32'(1));
    chk("midrst_rdy",  32'(rdy_o), 32'(1));
    chk("midrst_busy", 32'(busy),  32'(0));
    req = 2'b11;
    repeat (3) @(negedge clk_i);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) bus_cyc(2'b11, 1'b1, 1'b0, 1'b0);
    chk("post_reset_first_gnt", 32'(o_gnt), 32'(2'b01));
    for (int i = 0; i < 8; i++) bus_cyc(2'b00, 1'b1, 1'b0, 1'b0);

    // Random traffic, including mid-cycle request glitches
    r   = 2'b00;
    rdw = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0)  r   = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) rdw = ~rdw;
      rw = ($urandom_range(2) != 0);
      bus_cyc(r, rw, rdw, $urandom_range(7) == 0);
    end
    for (int i = 0; i < 8; i++) bus_cyc(2'b00, 1'b1, 1'b0, 1'b0);
    chk("final_rdy", 32'(rdy_o), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
